// File: rtl/discharge_responder.sv
// Responder side of the four-phase discharge handshake: drives the discharge switch,
// blanks and debounces the output-low comparator, then acknowledges or reports a timeout.
module discharge_responder #(
    parameter int BLANK_CNT = 4,
    parameter int DEB_CNT   = 8,
    parameter int TMO_CNT   = 2000
) (
    input  logic CELCLK,
    input  logic CELRSTN,
    input  logic CELV,
    input  logic CELG,
    input  logic SUB,
    input  logic dis_req,
    input  logic vlow,
    output logic dis_en,
    output logic dis_ack,
    output logic dis_err,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BLANK = 3'd1,
        DISCH = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [3:0]  BLANK_LIM = 4'(BLANK_CNT);
    localparam logic [3:0]  DEB_LIM   = 4'(DEB_CNT);
    localparam logic [11:0] TMO_LIM   = 12'(TMO_CNT);

    state_t      state_reg, state_next;
    logic [3:0]  blank_cnt_reg, blank_cnt_next;
    logic [3:0]  deb_cnt_reg, deb_cnt_next;
    logic [11:0] tmo_cnt_reg, tmo_cnt_next;
    logic        vlow_meta_reg, vlow_s_reg;
    logic        dis_en_reg, dis_ack_reg, dis_err_reg, busy_reg;
    logic        dis_en_next, dis_ack_next, dis_err_next, busy_next;

    logic [3:0]  blank_inc, deb_inc;
    logic [11:0] tmo_inc;

    // Power and substrate pins carry no logic; folded into a sink so they stay connected.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ SUB;

    // Saturating increments so no counter can ever wrap.
    assign blank_inc = (blank_cnt_reg == 4'hF)   ? blank_cnt_reg : blank_cnt_reg + 4'd1;
    assign deb_inc   = (deb_cnt_reg == 4'hF)     ? deb_cnt_reg   : deb_cnt_reg + 4'd1;
    assign tmo_inc   = (tmo_cnt_reg == 12'hFFF)  ? tmo_cnt_reg   : tmo_cnt_reg + 12'd1;

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state_reg     <= IDLE;
            blank_cnt_reg <= '0;
            deb_cnt_reg   <= '0;
            tmo_cnt_reg   <= '0;
            vlow_meta_reg <= 1'b0;
            vlow_s_reg    <= 1'b0;
            dis_en_reg    <= 1'b0;
            dis_ack_reg   <= 1'b0;
            dis_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            blank_cnt_reg <= blank_cnt_next;
            deb_cnt_reg   <= deb_cnt_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            vlow_meta_reg <= vlow;
            vlow_s_reg    <= vlow_meta_reg;
            dis_en_reg    <= dis_en_next;
            dis_ack_reg   <= dis_ack_next;
            dis_err_reg   <= dis_err_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        blank_cnt_next = blank_cnt_reg;
        deb_cnt_next   = deb_cnt_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (dis_req) begin
                    state_next     = BLANK;
                    blank_cnt_next = '0;
                    deb_cnt_next   = '0;
                    tmo_cnt_next   = '0;
                end
            end
            BLANK: begin
                if (!dis_req) begin
                    state_next = IDLE;
                end else begin
                    blank_cnt_next = blank_inc;
                    tmo_cnt_next   = tmo_inc;
                    if (tmo_inc == TMO_LIM) begin
                        state_next = FAULT;
                    end else if (blank_inc == BLANK_LIM) begin
                        state_next   = DISCH;
                        deb_cnt_next = '0;
                    end
                end
            end
            DISCH: begin
                if (!dis_req) begin
                    state_next = IDLE;
                end else begin
                    tmo_cnt_next = tmo_inc;
                    deb_cnt_next = vlow_s_reg ? deb_inc : 4'd0;
                    // Debounce completion takes priority over a coincident timeout.
                    if (vlow_s_reg && (deb_inc == DEB_LIM)) begin
                        state_next = DONE;
                    end else if (tmo_inc == TMO_LIM) begin
                        state_next = FAULT;
                    end
                end
            end
            DONE, FAULT: begin
                if (!dis_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they move on the same edge as the FSM.
    always_comb begin
        dis_en_next  = (state_next == BLANK) || (state_next == DISCH);
        busy_next    = (state_next == BLANK) || (state_next == DISCH);
        dis_ack_next = (state_next == DONE);
        dis_err_next = (state_next == FAULT);
    end

    assign dis_en  = dis_en_reg;
    assign dis_ack = dis_ack_reg;
    assign dis_err = dis_err_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_discharge_responder.sv
// Scoreboard bench for discharge_responder: default instance plus a short-timeout instance
// used for the debounce-versus-timeout tie case.
module tb_discharge_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, req, vlow, en, ack, err, busy;
    logic rst2_n, req2, vlow2, en2, ack2, err2, busy2;

    discharge_responder dut (
        .CELCLK(clk), .CELRSTN(rst_n), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .dis_req(req), .vlow(vlow),
        .dis_en(en), .dis_ack(ack), .dis_err(err), .busy(busy)
    );

    discharge_responder #(.BLANK_CNT(1), .DEB_CNT(4), .TMO_CNT(5)) dut2 (
        .CELCLK(clk), .CELRSTN(rst2_n), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .dis_req(req2), .vlow(vlow2),
        .dis_en(en2), .dis_ack(ack2), .dis_err(err2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int edge_no;
        bit is_err;
    } exp_t;
    exp_t exp_q[$];

    // Waits for the first ack or err of the chosen instance; seen stays -1 if the budget expires.
    task automatic wait_event(input bit second, input int budget,
                              output int seen, output bit saw_ack, output bit saw_err);
        int n = 0;
        seen = -1;
        saw_ack = 1'b0;
        saw_err = 1'b0;
        while (seen < 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (second ? (ack2 | err2) : (ack | err)) begin
                seen    = cyc;
                saw_ack = second ? ack2 : ack;
                saw_err = second ? err2 : err;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rst2_n = 1'b0;
        req = 1'b0; req2 = 1'b0; vlow = 1'b0; vlow2 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({en, ack, err, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle got %b want 0000", {en, ack, err, busy});
        end
        req = 1'b1;
        @(negedge clk);
        checks++;
        if ({en, busy} !== 2'b11) begin
            errors++;
            $display("FAIL reset_pre_busy got %b want 11", {en, busy});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({en, ack, err, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async got %b want 0000", {en, ack, err, busy});
        end
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({en, ack, err, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release got %b want 0000", {en, ack, err, busy});
        end
        $display("reset: async clear and release checked");
    endtask

    task automatic test_nominal();
        int c, seen;
        bit sa, se;
        exp_t x;
        vlow = 1'b1;
        repeat (3) @(negedge clk);
        c = cyc;
        req = 1'b1;
        exp_q.push_back('{edge_no: c + 13, is_err: 1'b0});
        @(negedge clk);
        checks++;
        if ({en, busy, ack, err} !== 4'b1100) begin
            errors++;
            $display("FAIL nominal_start got %b want 1100", {en, busy, ack, err});
        end
        wait_event(1'b0, 40, seen, sa, se);
        x = exp_q.pop_front();
        checks++;
        if (seen !== x.edge_no) begin
            errors++;
            $display("FAIL nominal_edge got %0d want %0d", seen - c, x.edge_no - c);
        end
        checks++;
        if ({sa, se, en, busy} !== {~x.is_err, x.is_err, 2'b00}) begin
            errors++;
            $display("FAIL nominal_kind got %b want %b", {sa, se, en, busy}, {~x.is_err, x.is_err, 2'b00});
        end
        req = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack, en} !== 2'b00) begin
            errors++;
            $display("FAIL nominal_release got %b want 00", {ack, en});
        end
        $display("nominal: ack at edge %0d", seen - c);
    endtask

    task automatic test_glitch();
        int c, seen;
        bit sa, se;
        exp_t x;
        vlow = 1'b1;
        @(negedge clk);
        c = cyc;
        req = 1'b1;
        // vlow low at sample edge 9 reaches the FSM at edge 11 while deb_cnt=5; restart completes at 19.
        exp_q.push_back('{edge_no: c + 19, is_err: 1'b0});
        repeat (8) @(negedge clk);
        vlow = 1'b0;
        @(negedge clk);
        vlow = 1'b1;
        wait_event(1'b0, 40, seen, sa, se);
        x = exp_q.pop_front();
        checks++;
        if (seen !== x.edge_no) begin
            errors++;
            $display("FAIL glitch_edge got %0d want %0d", seen - c, x.edge_no - c);
        end
        checks++;
        if ({sa, se} !== {~x.is_err, x.is_err}) begin
            errors++;
            $display("FAIL glitch_kind got %b want %b", {sa, se}, {~x.is_err, x.is_err});
        end
        req = 1'b0;
        @(negedge clk);
        $display("glitch: ack at edge %0d", seen - c);
    endtask

    task automatic test_timeout();
        int c, seen;
        bit sa, se;
        exp_t x;
        vlow = 1'b0;
        repeat (3) @(negedge clk);
        c = cyc;
        req = 1'b1;
        exp_q.push_back('{edge_no: c + 2001, is_err: 1'b1});
        wait_event(1'b0, 2100, seen, sa, se);
        x = exp_q.pop_front();
        checks++;
        if (seen !== x.edge_no) begin
            errors++;
            $display("FAIL timeout_edge got %0d want %0d", seen - c, x.edge_no - c);
        end
        checks++;
        if ({sa, se, en, busy} !== {~x.is_err, x.is_err, 2'b00}) begin
            errors++;
            $display("FAIL timeout_kind got %b want %b", {sa, se, en, busy}, {~x.is_err, x.is_err, 2'b00});
        end
        req = 1'b0;
        @(negedge clk);
        checks++;
        if ({err, ack} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_release got %b want 00", {err, ack});
        end
        $display("timeout: err at edge %0d", seen - c);
    endtask

    task automatic test_abort();
        int c, seen;
        bit sa, se, bad;
        exp_t x;
        vlow = 1'b1;
        repeat (3) @(negedge clk);
        c = cyc;
        req = 1'b1;
        bad = 1'b0;
        repeat (7) begin
            @(negedge clk);
            bad |= ack | err;
        end
        req = 1'b0;
        @(negedge clk);
        bad |= ack | err;
        checks++;
        if ({en, busy, bad} !== 3'b000) begin
            errors++;
            $display("FAIL abort_drop got %b want 000", {en, busy, bad});
        end
        c = cyc;
        req = 1'b1;
        exp_q.push_back('{edge_no: c + 13, is_err: 1'b0});
        wait_event(1'b0, 40, seen, sa, se);
        x = exp_q.pop_front();
        checks++;
        if (seen !== x.edge_no || {sa, se} !== {~x.is_err, x.is_err}) begin
            errors++;
            $display("FAIL abort_restart got edge %0d ack/err %b want edge %0d ack/err %b",
                     seen - c, {sa, se}, x.edge_no - c, {~x.is_err, x.is_err});
        end
        req = 1'b0;
        @(negedge clk);
        $display("abort: restart ack at edge %0d", seen - c);
    endtask

    task automatic test_simultaneous();
        int c, seen;
        bit sa, se;
        exp_t x;
        @(negedge clk);
        c = cyc;
        req2 = 1'b1;
        // Debounce reaches 4 and timeout reaches 5 on the same edge.
        exp_q.push_back('{edge_no: c + 6, is_err: 1'b0});
        wait_event(1'b1, 40, seen, sa, se);
        x = exp_q.pop_front();
        checks++;
        if (seen !== x.edge_no) begin
            errors++;
            $display("FAIL simul_edge got %0d want %0d", seen - c, x.edge_no - c);
        end
        checks++;
        if ({sa, se} !== {~x.is_err, x.is_err}) begin
            errors++;
            $display("FAIL simul_kind got %b want %b", {sa, se}, {~x.is_err, x.is_err});
        end
        req2 = 1'b0;
        @(negedge clk);
        checks++;
        if (ack2 !== 1'b0) begin
            errors++;
            $display("FAIL simul_release got %b want 0", ack2);
        end
        req2 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({en2, busy2} !== 2'b11) begin
            errors++;
            $display("FAIL simul_disch got %b want 11", {en2, busy2});
        end
        #2 rst2_n = 1'b0;
        #1;
        checks++;
        if ({en2, ack2, err2, busy2} !== 4'b0000) begin
            errors++;
            $display("FAIL simul_async_reset got %b want 0000", {en2, ack2, err2, busy2});
        end
        req2 = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        $display("simultaneous: ack at edge %0d, mid-DISCH reset checked", seen - c);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_abort();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
